// File: rtl/sp_deserializer.sv
// sp_deserializer
//   Serial-to-parallel packer. N-bit chunks arrive on a valid/ready input and
//   are packed into an M*N-bit word. The word is presented on a valid/ready
//   output together with the number of chunks it holds and a last flag.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (discards any partial word)
//   clear      synchronous flush of all state, wins over both handshakes
//   in_valid   sin carries a chunk
//   in_ready   block accepts a chunk this cycle
//   sin        input chunk, N bits
//   in_last    with the input handshake: this chunk closes the word
//   out_valid  q holds a completed word
//   out_ready  consumer takes q this cycle
//   q          assembled word, M*N bits; unwritten slots read as zero
//   out_count  number of valid chunks in q (1..M)
//   out_last   word was closed by in_last
module sp_deserializer #(
  parameter int N         = 4,
  parameter int M         = 2,
  parameter int MSB_FIRST = 1,
  localparam int CW       = $clog2(M + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    sin,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M*N-1:0]  q,
  output logic [CW-1:0]   out_count,
  output logic            out_last
);

  logic [M*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [M*N-1:0] merged;
  logic           accept;
  logic           done;
  int             slot;

  // Writes one chunk into slot k of a word. The loop walks only legal slot
  // indices, so no part-select can fall outside the word even when M=1.
  function automatic logic [M*N-1:0] place_chunk(input logic [M*N-1:0] word,
                                                  input logic [N-1:0]   chunk,
                                                  input int             k);
    logic [M*N-1:0] r;
    r = word;
    for (int i = 0; i < M; i++) begin
      if (i == k) r[i*N +: N] = chunk;
    end
    return r;
  endfunction

  // Input side is ready whenever the output register is empty or being
  // drained this cycle, which gives one word per M cycles with no bubble.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign slot     = (MSB_FIRST != 0) ? (M - 1 - int'(cnt)) : int'(cnt);
  assign merged   = place_chunk(acc, sin, slot);
  assign done     = accept && ((cnt == CW'(M - 1)) || in_last);

  // Accumulate / output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      q         <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      q         <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // A consumed word drops valid unless a new word lands on the same edge.
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (done) begin
          q         <= merged;
          out_count <= cnt + CW'(1);
          out_last  <= in_last;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= merged;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sp_deserializer.sv
module tb_sp_deserializer;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic in_valid;
  logic [3:0] sin;
  logic in_last;
  logic out_ready;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        ol0, ol1, ol2;
  logic [7:0]  q0, q1;
  logic [11:0] q2;
  logic [1:0]  oc0, oc1, oc2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Three configurations share one stimulus stream.
  sp_deserializer #(.N(4), .M(2), .MSB_FIRST(1)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir0),
    .sin(sin), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
    .q(q0), .out_count(oc0), .out_last(ol0));

  sp_deserializer #(.N(4), .M(2), .MSB_FIRST(0)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir1),
    .sin(sin), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .q(q1), .out_count(oc1), .out_last(ol1));

  sp_deserializer #(.N(4), .M(3), .MSB_FIRST(1)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir2),
    .sin(sin), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
    .q(q2), .out_count(oc2), .out_last(ol2));

  // Reference model: pending chunks are kept as a list; a finished word is
  // built arithmetically by shifting each chunk to its position.
  int        cfg_m   [3] = '{2, 2, 3};
  int        cfg_msb [3] = '{1, 0, 1};
  int        pend_n  [3];
  int        pend_v  [3][3];
  int        m_q     [3];
  int        m_cnt   [3];
  bit        m_last  [3];
  bit        m_vld   [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pend_n[i] = 0;
      m_q[i]    = 0;
      m_cnt[i]  = 0;
      m_last[i] = 1'b0;
      m_vld[i]  = 1'b0;
    end
  endtask

  function automatic bit model_ready(input int i, input bit ordy);
    return !m_vld[i] || ordy;
  endfunction

  task automatic model_advance(input bit v, input int s, input bit l,
                               input bit ordy, input bit clr);
    bit rdy;
    int w;
    if (clr) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      rdy = model_ready(i, ordy);
      if (m_vld[i] && ordy) m_vld[i] = 1'b0;
      if (v && rdy) begin
        pend_v[i][pend_n[i]] = s;
        pend_n[i]++;
        if (pend_n[i] == cfg_m[i] || l) begin
          w = 0;
          for (int j = 0; j < pend_n[i]; j++)
            w += pend_v[i][j] << (4 * ((cfg_msb[i] != 0) ? (cfg_m[i] - 1 - j) : j));
          m_q[i]    = w;
          m_cnt[i]  = pend_n[i];
          m_last[i] = l;
          m_vld[i]  = 1'b1;
          pend_n[i] = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " q0"},  32'(q0),  32'(m_q[0]));
    chk({tag, " q1"},  32'(q1),  32'(m_q[1]));
    chk({tag, " q2"},  32'(q2),  32'(m_q[2]));
    chk({tag, " oc0"}, 32'(oc0), 32'(m_cnt[0]));
    chk({tag, " oc1"}, 32'(oc1), 32'(m_cnt[1]));
    chk({tag, " oc2"}, 32'(oc2), 32'(m_cnt[2]));
    chk({tag, " ol0"}, 32'(ol0), 32'(m_last[0]));
    chk({tag, " ol1"}, 32'(ol1), 32'(m_last[1]));
    chk({tag, " ol2"}, 32'(ol2), 32'(m_last[2]));
    chk({tag, " ov0"}, 32'(ov0), 32'(m_vld[0]));
    chk({tag, " ov1"}, 32'(ov1), 32'(m_vld[1]));
    chk({tag, " ov2"}, 32'(ov2), 32'(m_vld[2]));
  endtask

  // One clock of stimulus: drive, check readiness mid-cycle, then check the
  // registered outputs just after the edge.
  task automatic step(input string tag, input bit v, input logic [3:0] s,
                      input bit l, input bit ordy, input bit clr);
    in_valid  = v;
    sin       = s;
    in_last   = l;
    out_ready = ordy;
    clear     = clr;
    #3;
    chk({tag, " ir0"}, 32'(ir0), 32'(model_ready(0, ordy)));
    chk({tag, " ir1"}, 32'(ir1), 32'(model_ready(1, ordy)));
    chk({tag, " ir2"}, 32'(ir2), 32'(model_ready(2, ordy)));
    @(posedge clk);
    #1;
    model_advance(v, int'(s), l, ordy, clr);
    check_outputs(tag);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; sin = '0; in_last = 1'b0; out_ready = 1'b1;
    model_reset();
    #12;
    check_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic pack, both orderings
    step("pack_a", 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    step("pack_5", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    chk("msb_first_word", 32'(q0), 32'h0A5);
    chk("lsb_first_word", 32'(q1), 32'h05A);
    chk("full_count", 32'(oc0), 32'd2);
    step("pack_idle", 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("valid_one_cycle", 32'(ov0), 32'd0);

    // Early close with in_last on M=3
    step("clr0", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    step("last_3", 1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
    chk("early_last_word", 32'(q2), 32'h300);
    chk("early_last_count", 32'(oc2), 32'd1);
    step("m3_1", 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    step("m3_2", 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
    step("m3_4", 1'b1, 4'h4, 1'b0, 1'b1, 1'b0);
    chk("m3_full_word", 32'(q2), 32'h124);

    // Back-pressure
    step("clr1", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    step("bp_a", 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    step("bp_5", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("bp_stall", 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    chk("bp_hold", 32'(q0), 32'h0A5);
    step("bp_c", 1'b1, 4'hC, 1'b0, 1'b1, 1'b0);
    step("bp_d", 1'b1, 4'hD, 1'b0, 1'b1, 1'b0);
    chk("bp_next_word", 32'(q0), 32'h0CD);

    // Continuous stream
    step("clr2", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) step("stream", 1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
    chk("stream_last_word", 32'(q0), 32'h078);

    // Asynchronous reset mid-word, with a non-zero q held
    step("clr3", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    step("rst_a", 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    step("rst_5", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    step("rst_f", 1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    #1;
    reset = 1'b0;
    step("rst_1", 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    step("rst_2", 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
    chk("after_reset_word", 32'(q0), 32'h012);

    // Synchronous clear mid-word
    step("sc_f", 1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
    step("sc_clear", 1'b1, 4'h7, 1'b1, 1'b1, 1'b1);
    chk("clear_zero_q", 32'(q0), 32'h0);
    step("sc_1", 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
    step("sc_2", 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
    chk("after_clear_word", 32'(q0), 32'h012);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 60) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
